ntt_stage_seq: RTL and testbench

NTT_STAGE_SEQ -- requirements
Module: ntt_stage_seq

---
 rtl/ntt_stage_seq.sv | 123 ++++++++++++
 tb/tb_ntt_stage_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_seq.sv
// ntt_stage_seq: sequences the 7 NTT/INTT stages, issuing one len/grp_idx beat per butterfly group.
// Latency: first beat one cycle after start; done pulses 7*NUM_GRP beats later (plus NUM_GRP scale beats for INTT when enabled).
// Backpressure: a beat advances only when bu_valid && bu_ready; all beat outputs hold while bu_ready is low.
// Optional feature: define NTT_INV_SCALE_EN to append NUM_GRP n^-1 scaling beats after an inverse transform.
module ntt_stage_seq #(
    parameter int NUM_GRP = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode_ntt,
    output logic [7:0]                 len,
    output logic                       is_NTT,
    output logic [2:0]                 stage_idx,
    output logic [$clog2(NUM_GRP)-1:0] grp_idx,
    output logic                       bu_valid,
    input  logic                       bu_ready,
    output logic                       scale_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int GW = $clog2(NUM_GRP);
    localparam logic [GW-1:0] LAST_GRP = GW'(NUM_GRP - 1);
    localparam logic [2:0]    LAST_STAGE = 3'd6;

`ifdef NTT_INV_SCALE_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCALE, S_DONE} state_t;
    logic scale_q;
    assign scale_valid = scale_q;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    assign scale_valid = 1'b0;
`endif

    state_t state;

    // Main sequencer: state, stage/group counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            len       <= 8'd0;
            is_NTT    <= 1'b0;
            stage_idx <= 3'd0;
            grp_idx   <= '0;
            bu_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef NTT_INV_SCALE_EN
            scale_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_NTT    <= mode_ntt;
                        stage_idx <= 3'd0;
                        grp_idx   <= '0;
                        len       <= mode_ntt ? 8'd128 : 8'd2;
                        bu_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bu_ready) begin
                        if (grp_idx != LAST_GRP) begin
                            grp_idx <= grp_idx + 1'b1;
                        end else begin
                            grp_idx <= '0;
                            if (stage_idx != LAST_STAGE) begin
                                stage_idx <= stage_idx + 3'd1;
                                len       <= is_NTT ? (len >> 1) : (len << 1);
                            end else begin
                                // Last stage finished: len leaves the 2..128 range only by dropping to 0.
                                len <= 8'd0;
`ifdef NTT_INV_SCALE_EN
                                if (!is_NTT) begin
                                    scale_q <= 1'b1;
                                    state   <= S_SCALE;
                                end else begin
                                    bu_valid <= 1'b0;
                                    done     <= 1'b1;
                                    state    <= S_DONE;
                                end
`else
                                bu_valid <= 1'b0;
                                done     <= 1'b1;
                                state    <= S_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef NTT_INV_SCALE_EN
                S_SCALE: begin
                    if (bu_ready) begin
                        if (grp_idx != LAST_GRP) begin
                            grp_idx <= grp_idx + 1'b1;
                        end else begin
                            grp_idx  <= '0;
                            scale_q  <= 1'b0;
                            bu_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    // start is deliberately ignored here; a new transform needs an IDLE cycle.
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_stage_seq.sv
// Directed bench for ntt_stage_seq: table of whole-transform vectors plus hand-written
// reset-abort and start-held sequences. Cycle 1 is the first cycle after the edge that samples start.
`timescale 1ns/1ps
module tb_ntt_stage_seq;
    localparam int NG = 16;
    localparam int GW = $clog2(NG);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode_ntt;
    logic [7:0]    len;
    logic          is_NTT;
    logic [2:0]    stage_idx;
    logic [GW-1:0] grp_idx;
    logic          bu_valid;
    logic          bu_ready;
    logic          scale_valid;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef NTT_INV_SCALE_EN
    localparam int INTT_DONE  = 129;
    localparam int INTT_SCALE = 16;
`else
    localparam int INTT_DONE  = 113;
    localparam int INTT_SCALE = 0;
`endif

    typedef struct {
        logic mode;
        int   stall_at;
        int   stall_n;
        int   stall_len;
        int   stall_grp;
        int   first_len;
        int   exp_done;
        int   exp_scale;
    } vec_t;

    always #5 clk = ~clk;

    ntt_stage_seq #(.NUM_GRP(NG)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_ntt(mode_ntt),
        .len(len), .is_NTT(is_NTT), .stage_idx(stage_idx), .grp_idx(grp_idx),
        .bu_valid(bu_valid), .bu_ready(bu_ready), .scale_valid(scale_valid),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cyc = 1;
        int beats[8];
        int order_err = 0;
        int mode_err = 0;
        int stall_err = 0;
        int scale_beats = 0;
        int done_cyc = -1;
        int max_stage = 0;
        int prev_len;
        for (int i = 0; i < 8; i++) beats[i] = 0;
        mode_ntt = v.mode;
        bu_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("v%0d_first_valid", id), bu_valid, 1);
        check($sformatf("v%0d_first_len", id), len, v.first_len);
        prev_len = len;
        while (cyc <= 300) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (is_NTT !== v.mode) mode_err++;
            if (int'(stage_idx) > max_stage) max_stage = stage_idx;
            if (bu_valid && !scale_valid) begin
                if (len != prev_len && int'(len) != (v.mode ? prev_len / 2 : prev_len * 2)) order_err++;
                prev_len = len;
            end
            if (v.stall_n > 0 && cyc >= v.stall_at && cyc <= v.stall_at + v.stall_n)
                if (int'(len) != v.stall_len || int'(grp_idx) != v.stall_grp) stall_err++;
            bu_ready = !(v.stall_n > 0 && cyc >= v.stall_at && cyc < v.stall_at + v.stall_n);
            if (bu_valid && bu_ready) begin
                if (scale_valid) begin
                    scale_beats++;
                    if (len != 8'd0) order_err++;
                end else if (len != 8'd0) begin
                    beats[$clog2(len)]++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bu_ready = 1'b1;
        check($sformatf("v%0d_done_cycle", id), done_cyc, v.exp_done);
        for (int i = 1; i < 8; i++)
            check($sformatf("v%0d_beats_len%0d", id, 1 << i), beats[i], 16);
        check($sformatf("v%0d_len_order_err", id), order_err, 0);
        check($sformatf("v%0d_is_ntt_err", id), mode_err, 0);
        check($sformatf("v%0d_scale_beats", id), scale_beats, v.exp_scale);
        check($sformatf("v%0d_max_stage", id), max_stage, 6);
        check($sformatf("v%0d_done_cycle_valid", id), bu_valid, 0);
        check($sformatf("v%0d_done_cycle_len", id), len, 0);
        if (v.stall_n > 0) check($sformatf("v%0d_stall_hold_err", id), stall_err, 0);
        @(posedge clk); #1;
        check($sformatf("v%0d_idle_done", id), done, 0);
        check($sformatf("v%0d_idle_busy", id), busy, 0);
        check($sformatf("v%0d_idle_valid", id), bu_valid, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int dcnt;
        int first_done;
        vecs[0] = '{1'b1, 0,  0, 0,  0, 128, 113,       0};
        vecs[1] = '{1'b0, 0,  0, 0,  0, 2,   INTT_DONE, INTT_SCALE};
        vecs[2] = '{1'b1, 38, 3, 32, 5, 128, 116,       0};
        vecs[3] = '{1'b0, 10, 2, 2,  9, 2,   INTT_DONE + 2, INTT_SCALE};

        rst = 1'b1; start = 1'b0; mode_ntt = 1'b1; bu_ready = 1'b1;
        #3;
        check("reset_outputs", int'({len, is_NTT, stage_idx, grp_idx, bu_valid, scale_valid, busy, done}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_start_busy", busy, 0);
        check("idle_no_start_valid", bu_valid, 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Reset in the middle of stage 4 aborts without a done pulse.
        mode_ntt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 68; c++) begin
            @(posedge clk); #1;
        end
        check("abort_pre_stage", stage_idx, 4);
        check("abort_pre_len", len, 8);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", int'({len, is_NTT, stage_idx, grp_idx, bu_valid, scale_valid, busy, done}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_idle_busy", busy, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_len", len, 128);
        check("restart_stage", stage_idx, 0);
        check("restart_grp", grp_idx, 0);
        check("restart_is_ntt", is_NTT, 1);
        do_reset();

        // start held high for an entire transform and beyond.
        mode_ntt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        dcnt = 0; first_done = -1;
        for (int c = 1; c <= 116; c++) begin
            if (done) begin
                dcnt++;
                if (first_done < 0) first_done = c;
            end
            if (c == 50) check("held_mid_grp", grp_idx, 1);
            if (c == 114) begin
                check("held_idle_busy", busy, 0);
                check("held_idle_valid", bu_valid, 0);
            end
            if (c == 115) begin
                check("held_restart_valid", bu_valid, 1);
                check("held_restart_len", len, 128);
                check("held_restart_stage", stage_idx, 0);
            end
            if (c < 116) begin
                @(posedge clk); #1;
            end
        end
        check("held_done_cycle", first_done, 113);
        check("held_done_count", dcnt, 1);
        start = 1'b0;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
